// File: rtl/xbar_allocator_pkg.sv
// Shared types and constants for the 5-port crossbar allocator.
package xbar_pkg;

  localparam int unsigned NUM_PORTS  = 5;
  localparam int unsigned PORT_IDX_W = 3;
  localparam int unsigned FLIT_W     = 16;

  typedef enum logic [PORT_IDX_W-1:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_t;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Next port index in round-robin order, wrapping LOCAL back to NORTH.
  function automatic port_idx_t rr_next(input port_idx_t p);
    return (p == port_idx_t'(LOCAL)) ? port_idx_t'(NORTH) : p + 3'd1;
  endfunction

endpackage

// File: rtl/xbar_allocator_if.sv
// Request/grant bundle between the input queues, the allocator and the crossbar.
interface xbar_allocator_if;
  import xbar_pkg::*;

  logic [NUM_PORTS-1:0]            q_valid_i;
  logic [NUM_PORTS*PORT_IDX_W-1:0] q_dest_i;
  logic [NUM_PORTS-1:0]            q_tail_i;
  logic [NUM_PORTS-1:0]            out_ready_i;
  logic [NUM_PORTS-1:0]            pop_o;
  logic [NUM_PORTS-1:0]            grant_o;
  logic [NUM_PORTS*PORT_IDX_W-1:0] sel_o;

  modport master (
    output q_valid_i, q_dest_i, q_tail_i, out_ready_i,
    input  pop_o, grant_o, sel_o
  );

  modport slave (
    input  q_valid_i, q_dest_i, q_tail_i, out_ready_i,
    output pop_o, grant_o, sel_o
  );

endinterface

// File: rtl/xbar_allocator_rr_arbiter5.sv
// Five-way round-robin arbiter: search begins one past ptr_i and wraps 4->0.
module rr_arbiter5
  import xbar_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_idx_t            ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_idx_t            idx_o
);

  port_idx_t cand;
  logic      found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = ptr_i;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = rr_next(cand);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/xbar_allocator.sv
// Per-output round-robin switch allocator with zero-cycle grant/pop.
// Define XBAR_ALLOC_WORMHOLE_EN to hold an output for a whole packet (head to tail).
module xbar_allocator
  import xbar_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  xbar_allocator_if.slave  bus
);

  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
  port_idx_t            arb_idx [NUM_PORTS];
  port_idx_t            ptr_q   [NUM_PORTS];
  port_idx_t            ptr_d   [NUM_PORTS];

  logic [NUM_PORTS-1:0]            pop;
  logic [NUM_PORTS-1:0]            grant;
  logic [NUM_PORTS*PORT_IDX_W-1:0] sel;

`ifdef XBAR_ALLOC_WORMHOLE_EN
  alloc_state_t         state_q [NUM_PORTS];
  alloc_state_t         state_d [NUM_PORTS];
  port_idx_t            owner_q [NUM_PORTS];
  port_idx_t            owner_d [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_locked;

  // An input that owns any output may not compete for a different one.
  always_comb begin
    in_locked = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] == LOCKED) in_locked[owner_q[o]] = 1'b1;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ^bus.q_tail_i;
`endif

  always_comb begin
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
`ifdef XBAR_ALLOC_WORMHOLE_EN
        if (state_q[o] == LOCKED)
          req[o][i] = (owner_q[o] == port_idx_t'(i)) && bus.q_valid_i[i];
        else
          req[o][i] = bus.q_valid_i[i] && !in_locked[i] &&
                      (bus.q_dest_i[PORT_IDX_W*i +: PORT_IDX_W] == port_idx_t'(o));
`else
        req[o][i] = bus.q_valid_i[i] &&
                    (bus.q_dest_i[PORT_IDX_W*i +: PORT_IDX_W] == port_idx_t'(o));
`endif
        req[o][i] = req[o][i] && bus.out_ready_i[o] && !rst;
      end
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter5 u_arb (
      .req_i (req[g]),
      .ptr_i (ptr_q[g]),
      .gnt_o (arb_gnt[g]),
      .idx_o (arb_idx[g])
    );
  end

  // Each input requests at most one output, so OR-ing grants gives a unique pop.
  always_comb begin
    pop   = '0;
    grant = '0;
    sel   = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      ptr_d[o] = ptr_q[o];
      grant[o] = |arb_gnt[o];
      pop      = pop | arb_gnt[o];
      sel[PORT_IDX_W*o +: PORT_IDX_W] = arb_idx[o];
      if (grant[o]) ptr_d[o] = arb_idx[o];
    end
  end

`ifdef XBAR_ALLOC_WORMHOLE_EN
  always_comb begin
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      case (state_q[o])
        IDLE: begin
          if (grant[o] && !bus.q_tail_i[arb_idx[o]]) begin
            state_d[o] = LOCKED;
            owner_d[o] = arb_idx[o];
          end
        end
        LOCKED: begin
          if (grant[o] && bus.q_tail_i[owner_q[o]]) state_d[o] = IDLE;
        end
        default: state_d[o] = IDLE;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        ptr_q[o] <= port_idx_t'(LOCAL);
`ifdef XBAR_ALLOC_WORMHOLE_EN
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
`endif
      end
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        ptr_q[o] <= ptr_d[o];
`ifdef XBAR_ALLOC_WORMHOLE_EN
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
`endif
      end
    end
  end

  assign bus.pop_o   = pop;
  assign bus.grant_o = grant;
  assign bus.sel_o   = sel;

endmodule
